csa_row_sequencer: RTL and testbench

- Iterative front end of the carry-save array multiplier.
- Accepts an unsigned multiplicand/multiplier pair through a valid/ready handshake. Generates all partial products, then computes one carry-save adder row per clock.
- Presents the completed partial_prd / partial_sum_csa / partial_carry_csa arrays to final_sum_carry_gen, which resolves them into mult_out.
- Trades area for latency compared with the fully combinational array.

---
 rtl/csa_row_sequencer.sv | 134 +++++++++++++
 tb/tb_csa_row_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_row_sequencer.sv
// csa_row_sequencer: iterative carry-save front end; one CSA row per clock (CSA_PIPE_ACCEPT_EN: back-to-back accept in DONE).
// Latency: out_valid rises N-1 cycles after the accept edge.
// Backpressure: arrays held in DONE until out_ready; in_ready low outside IDLE unless pipelined accept is built in.
module csa_row_sequencer #(
  parameter int MAX_MLTCND_BITS = 12,
  parameter int MAX_MLTPLR_BITS = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MAX_MLTCND_BITS-1:0] mltcnd,
  input  logic [MAX_MLTPLR_BITS-1:0] mltplr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAX_MLTCND_BITS-1:0] partial_prd       [MAX_MLTPLR_BITS-1:0],
  output logic [MAX_MLTCND_BITS-1:0] partial_sum_csa   [MAX_MLTPLR_BITS-2:0],
  output logic [MAX_MLTCND_BITS-1:0] partial_carry_csa [MAX_MLTPLR_BITS-2:0],
  output logic                       busy
);

  localparam int M  = MAX_MLTCND_BITS;
  localparam int N  = MAX_MLTPLR_BITS;
  localparam int KW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [KW-1:0] LAST_ROW = KW'(N - 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] row;
  logic          load;
  logic          step_row;

  logic [M-1:0] pp_next, sum_prev, carry_prev;
  logic [M-1:0] in1, in2, in3;
  logic [M-1:0] row_sum, row_carry;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step_row  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy     = 1'b1;
        step_row = 1'b1;
        if (row == LAST_ROW) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
`ifdef CSA_PIPE_ACCEPT_EN
        // Handing off the current result frees the array for the next pair on the same edge.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
`else
        if (out_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row operand selection by counter; row 0 folds pp[0] in place of a previous sum.
  always_comb begin
    pp_next    = '0;
    sum_prev   = '0;
    carry_prev = '0;
    for (int r = 0; r < N - 1; r++) begin
      if (row == KW'(r)) pp_next = partial_prd[r+1];
    end
    for (int r = 0; r < N - 2; r++) begin
      if (row == KW'(r + 1)) begin
        sum_prev   = partial_sum_csa[r];
        carry_prev = partial_carry_csa[r];
      end
    end
  end

  // The shift aligns the previous row's sum to this row's weight and feeds 0 into the MSB.
  assign in1       = (row == '0) ? (partial_prd[0] >> 1) : (sum_prev >> 1);
  assign in2       = pp_next;
  assign in3       = (row == '0) ? '0 : carry_prev;
  assign row_sum   = in1 ^ in2 ^ in3;
  assign row_carry = (in1 & in2) | (in1 & in3) | (in2 & in3);

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      for (int i = 0; i < N; i++) partial_prd[i] <= '0;
      for (int i = 0; i < N - 1; i++) begin
        partial_sum_csa[i]   <= '0;
        partial_carry_csa[i] <= '0;
      end
    end else if (load) begin
      row <= '0;
      for (int i = 0; i < N; i++) partial_prd[i] <= mltplr[i] ? mltcnd : '0;
      for (int i = 0; i < N - 1; i++) begin
        partial_sum_csa[i]   <= '0;
        partial_carry_csa[i] <= '0;
      end
    end else if (step_row) begin
      row <= (row == LAST_ROW) ? '0 : row + KW'(1);
      for (int r = 0; r < N - 1; r++) begin
        if (row == KW'(r)) begin
          partial_sum_csa[r]   <= row_sum;
          partial_carry_csa[r] <= row_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_csa_row_sequencer.sv
// Bench for csa_row_sequencer: cycle-level model of handshake/arrays plus arithmetic recombination of the result.
module tb_csa_row_sequencer;

  localparam int M = 12;
  localparam int N = 9;
`ifdef CSA_PIPE_ACCEPT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef logic [M-1:0] pp_arr_t  [N-1:0];
  typedef logic [M-1:0] row_arr_t [N-2:0];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [M-1:0] mltcnd = '0;
  logic [N-1:0] mltplr = '0;
  logic         in_ready, out_valid, busy;
  pp_arr_t      pp_o;
  row_arr_t     sum_o, carry_o;

  int n_cmp = 0;
  int n_err = 0;

  csa_row_sequencer #(.MAX_MLTCND_BITS(M), .MAX_MLTPLR_BITS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mltcnd(mltcnd), .mltplr(mltplr),
    .out_valid(out_valid), .out_ready(out_ready),
    .partial_prd(pp_o), .partial_sum_csa(sum_o), .partial_carry_csa(carry_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Recombine the arrays into the product using the bit weights of each row.
  function automatic logic [63:0] inv(pp_arr_t p, row_arr_t s, row_arr_t c);
    logic [63:0] r;
    r = 64'(p[0][0]);
    for (int i = 0; i < N - 1; i++) r = r + (64'(s[i][0]) << (i + 1));
    r = r + (((64'(s[N-2]) >> 1) + 64'(c[N-2])) << N);
    return r;
  endfunction

  // Reference rows built bit by bit as counted full adders.
  function automatic void golden(input logic [M-1:0] a, input logic [N-1:0] b,
                                 output pp_arr_t p, output row_arr_t s, output row_arr_t c);
    int x1, x2, x3, t;
    for (int i = 0; i < N; i++) p[i] = b[i] ? a : '0;
    for (int k = 0; k < N - 1; k++) begin
      for (int j = 0; j < M; j++) begin
        if (j == M - 1)  x1 = 0;
        else if (k == 0) x1 = int'(p[0][j+1]);
        else             x1 = int'(s[k-1][j+1]);
        x2 = int'(p[k+1][j]);
        x3 = (k == 0) ? 0 : int'(c[k-1][j]);
        t  = x1 + x2 + x3;
        s[k][j] = (t % 2) == 1;
        c[k][j] = t >= 2;
      end
    end
  endfunction

  function automatic bit arr_eq(pp_arr_t ap, row_arr_t as_, row_arr_t ac,
                                pp_arr_t bp, row_arr_t bs, row_arr_t bc);
    bit ok = 1'b1;
    for (int i = 0; i < N; i++) if (ap[i] !== bp[i]) ok = 1'b0;
    for (int i = 0; i < N - 1; i++) if (as_[i] !== bs[i] || ac[i] !== bc[i]) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit all_zero(pp_arr_t p, row_arr_t s, row_arr_t c);
    bit ok = 1'b1;
    for (int i = 0; i < N; i++) if (p[i] !== '0) ok = 1'b0;
    for (int i = 0; i < N - 1; i++) if (s[i] !== '0 || c[i] !== '0) ok = 1'b0;
    return ok;
  endfunction

  // Behavioural model: idle / counting down N-1 row cycles / holding a result.
  bit           mv = 1'b0;
  int           calc_left = 0;
  bit           m_done = 1'b0;
  bit           m_idle, exp_rdy;
  pp_arr_t      e_pp;
  row_arr_t     e_s, e_c;
  logic [M-1:0] cur_a;
  logic [N-1:0] cur_b;
  int           n_deliv = 0;

  task automatic model_accept();
    cur_a = mltcnd;
    cur_b = mltplr;
    golden(mltcnd, mltplr, e_pp, e_s, e_c);
    calc_left = N - 1;
    m_done = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      m_idle  = (calc_left == 0) && !m_done;
      exp_rdy = m_idle || (m_done && FEAT && out_ready);
      if (mv) begin
        check("ctrl", {61'd0, out_valid, in_ready, busy}, {61'd0, m_done, exp_rdy, !m_idle});
        if (m_idle || m_done)
          check("arrays", 64'(arr_eq(pp_o, sum_o, carry_o, e_pp, e_s, e_c)), 64'd1);
        if (m_done && out_ready) begin
          check("invariant", inv(pp_o, sum_o, carry_o), 64'(cur_a) * 64'(cur_b));
          n_deliv++;
        end
      end
      if (rst) begin
        mv = 1'b1;
        calc_left = 0;
        m_done = 1'b0;
        for (int i = 0; i < N; i++) e_pp[i] = '0;
        for (int i = 0; i < N - 1; i++) begin
          e_s[i] = '0;
          e_c[i] = '0;
        end
      end else if (mv) begin
        if (m_idle) begin
          if (in_valid) model_accept();
        end else if (calc_left > 0) begin
          calc_left--;
          if (calc_left == 0) m_done = 1'b1;
        end else if (out_ready) begin
          m_done = 1'b0;
          if (FEAT && in_valid) model_accept();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [M-1:0] a, input logic [N-1:0] b, output int lat);
    mltcnd = a;
    mltplr = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check(name, {61'd0, out_valid, in_ready, busy}, 64'b010);
  endtask

  pp_arr_t      snap_pp;
  row_arr_t     snap_s, snap_c;
  logic [63:0]  d_prod [3];
  int           d_t [3];

  initial begin
    int lat, guard, start, idx, nd;
    bit ok, acc;
    logic [M-1:0] a_tab [3];
    logic [N-1:0] b_tab [3];
    logic [63:0]  p_tab [3];
    a_tab = '{12'd3, 12'd6, 12'd100};
    b_tab = '{9'd4, 9'd7, 9'd255};
    p_tab = '{64'd12, 64'd42, 64'd25500};
    for (int i = 0; i < 3; i++) begin
      d_prod[i] = '0;
      d_t[i] = 0;
    end

    step();
    step();
    rst = 1'b0;
    check("reset_ctrl", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("reset_zero", 64'(all_zero(pp_o, sum_o, carry_o)), 64'd1);

    do_op(12'd5, 9'd3, lat);
    check("lat_5x3", 64'(lat), 64'(N - 1));
    check("prod_5x3", inv(pp_o, sum_o, carry_o), 64'd15);
    check("pp0_5x3", 64'(pp_o[0]), 64'd5);
    check("pp1_5x3", 64'(pp_o[1]), 64'd5);
    ok = 1'b1;
    for (int i = 2; i < N; i++) if (pp_o[i] !== '0) ok = 1'b0;
    check("pp_hi_5x3", 64'(ok), 64'd1);
    release_out("idle_after_5x3");

    do_op(12'hFFF, 9'h1FF, lat);
    check("prod_max", inv(pp_o, sum_o, carry_o), 64'd2092545);
    ok = 1'b1;
    for (int i = 0; i < N; i++) if (pp_o[i] !== 12'hFFF) ok = 1'b0;
    check("pp_max", 64'(ok), 64'd1);
    snap_pp = pp_o;
    snap_s  = sum_o;
    snap_c  = carry_o;
    mltcnd = 12'd123;
    mltplr = 9'd45;
    in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    check("bp_ctrl", 64'(ok), 64'd1);
    check("bp_hold", 64'(arr_eq(pp_o, sum_o, carry_o, snap_pp, snap_s, snap_c)), 64'd1);
    in_valid = 1'b0;
    release_out("idle_after_bp");
    check("retain_max", inv(pp_o, sum_o, carry_o), 64'd2092545);

    mltcnd = 12'd200;
    mltplr = 9'd300;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("calc_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ctrl", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("midrst_zero", 64'(all_zero(pp_o, sum_o, carry_o)), 64'd1);
    do_op(12'd7, 9'd9, lat);
    check("lat_7x9", 64'(lat), 64'(N - 1));
    check("prod_7x9", inv(pp_o, sum_o, carry_o), 64'd63);
    release_out("idle_after_7x9");

    start = n_deliv;
    guard = 0;
    while (n_deliv < start + 1000 && guard < 30000) begin
      in_valid  = 1'($urandom_range(0, 1));
      mltcnd    = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 7) == 0) ? '1 : M'($urandom);
      mltplr    = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
      guard++;
    end
    check("rand_deliv", 64'(n_deliv - start), 64'd1000);

    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (busy && guard < 50) begin
      step();
      guard++;
    end
    check("drain", {63'd0, busy}, 64'd0);

    idx = 0;
    nd = 0;
    mltcnd = a_tab[0];
    mltplr = b_tab[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      acc = in_valid && in_ready;
      if (out_valid && nd < 3) begin
        d_prod[nd] = inv(pp_o, sum_o, carry_o);
        d_t[nd] = t;
        nd++;
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          mltcnd = a_tab[idx];
          mltplr = b_tab[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("b2b_count", 64'(nd), 64'd3);
    for (int i = 0; i < 3; i++) check("b2b_prod", d_prod[i], p_tab[i]);
    for (int i = 1; i < 3; i++) check("b2b_spacing", 64'(d_t[i] - d_t[i-1]), FEAT ? 64'(N) : 64'(N + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
